bcd_seg7_scan: RTL and testbench

- Downstream consumer of the mod-10 BCD counter digits.
- Latches NDIG packed BCD digits on a load strobe and decodes each to seven-segment form.
- Time-multiplexes the digits onto one shared segment bus with one enable line per digit, driving the board display directly.
- A built-in prescaler sets the scan rate and emits one pulse per completed frame.

---
 rtl/bcd_seg7_scan.sv | 112 +++++++++++
 tb/tb_bcd_seg7_scan.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: latches NDIG packed BCD digits and scans them onto a shared seven-segment bus
//   clki        rising-edge clock
//   reset       asynchronous, active-high reset
//   digits_in   packed BCD, digit i = digits_in[4i+3:4i], digit 0 least significant
//   dp_in       decimal point request per digit
//   load        strobe capturing digits_in and dp_in
//   an          one-hot digit enables
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point of the enabled digit
//   frame_done  one-cycle pulse when the scan wraps from the last digit back to digit 0
//   Build option SEG_BLANK_LEADING_EN blanks leading zero digits (digit 0 always shown).
//   ACTIVE_LOW=1 inverts an/seg/dp for common-anode displays.
module bcd_seg7_scan #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                clki,
    input  logic                reset,
    input  logic [4*NDIG-1:0]   digits_in,
    input  logic [NDIG-1:0]     dp_in,
    input  logic                load,
    output logic [NDIG-1:0]     an,
    output logic [6:0]          seg,
    output logic                dp,
    output logic                frame_done
);
    localparam int   IW  = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam int   PW  = $clog2(REFRESH_DIV);
    localparam logic POL = ACTIVE_LOW != 0;

    logic [4*NDIG-1:0] digit_q;
    logic [NDIG-1:0]   dp_q;
    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic              tc, wrap;
    logic [3:0]        cur;
    logic              cur_dp, cur_blank;
    logic [NDIG-1:0]   onehot;
    logic [6:0]        glyph;

    assign tc   = presc == PW'(REFRESH_DIV - 1);
    assign wrap = tc && idx == IW'(NDIG - 1);

    always_comb begin
        cur    = '0;
        cur_dp = 1'b0;
        onehot = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                cur       = digit_q[4*i +: 4];
                cur_dp    = dp_q[i];
                onehot[i] = 1'b1;
            end
        end
    end

`ifdef SEG_BLANK_LEADING_EN
    // Walk from the most significant digit down; zrun stays set while every digit so far is zero.
    always_comb begin
        logic zrun;
        zrun      = 1'b1;
        cur_blank = 1'b0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            zrun = zrun && digit_q[4*i +: 4] == 4'd0;
            if (idx == IW'(i) && i != 0) cur_blank = zrun;
        end
    end
`else
    assign cur_blank = 1'b0;
`endif

    always_comb begin
        case (cur)
            4'd0:    glyph = 7'b0111111;
            4'd1:    glyph = 7'b0000110;
            4'd2:    glyph = 7'b1011011;
            4'd3:    glyph = 7'b1001111;
            4'd4:    glyph = 7'b1100110;
            4'd5:    glyph = 7'b1101101;
            4'd6:    glyph = 7'b1111101;
            4'd7:    glyph = 7'b0000111;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1101111;
            default: glyph = 7'b1000000;
        endcase
    end

    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            digit_q    <= '0;
            dp_q       <= '0;
            presc      <= '0;
            idx        <= '0;
            an         <= {NDIG{POL}};
            seg        <= {7{POL}};
            dp         <= POL;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                digit_q <= digits_in;
                dp_q    <= dp_in;
            end
            presc <= tc ? '0 : presc + 1'b1;
            if (tc) idx <= wrap ? '0 : idx + 1'b1;
            frame_done <= wrap;
            an         <= onehot ^ {NDIG{POL}};
            seg        <= (cur_blank ? 7'd0 : glyph) ^ {7{POL}};
            dp         <= cur_dp ^ POL;
        end
    end
endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb_bcd_seg7_scan: directed self-checking bench for bcd_seg7_scan (NDIG=4, REFRESH_DIV=4, ACTIVE_LOW=1)
module tb_bcd_seg7_scan;
    logic        clki = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_done;
    int          tests = 0, fails = 0, cyc = 0;

`ifdef SEG_BLANK_LEADING_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic [6:0] code [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    logic [6:0] exp1259 [4] = '{7'h10, 7'h12, 7'h24, 7'h79};

    always #5 clki = ~clki;

    bcd_seg7_scan #(.NDIG(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
        .clki(clki), .reset(reset), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clki);
        #1;
        cyc++;
    endtask

    function automatic int shown();
        return ((cyc - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] an_of(input int d);
        return ~(4'b0001 << d);
    endfunction

    task automatic goto(input int d);
        for (int k = 0; k < 16 && shown() != d; k++) tick();
    endtask

    task automatic check_digit(input string tag, input int d, input logic [6:0] s);
        goto(d);
        check({tag, "_an"}, 32'(an), 32'(an_of(d)));
        check({tag, "_seg"}, 32'(seg), 32'(s));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p);
        digits_in = v;
        dp_in = p;
        load = 1'b1;
        tick();
        load = 1'b0;
        digits_in = 16'hFFFF;
        dp_in = 4'hF;
        tick();
    endtask

    initial begin
        int pulses, first;
        logic [15:0] v;
        repeat (2) @(posedge clki);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_fd", 32'(frame_done), 32'h0);
        reset = 1'b0;
        tick();
        check("first_an", 32'(an), 32'hE);
        check("first_seg", 32'(seg), 32'h40);
        pulses = 0;
        first = 0;
        for (int k = 1; k < 48; k++) begin
            tick();
            if (frame_done) begin
                pulses++;
                if (first == 0) first = cyc;
            end
        end
        check("fd_count", 32'(pulses), 32'd3);
        check("fd_first", 32'(first), 32'd16);

        do_load(16'h1259, 4'b0100);
        check("l1_an0", 32'(an), 32'hE);
        check("l1_seg0", 32'(seg), 32'h10);
        check("l1_dp0", 32'(dp), 32'h1);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("l1_an", 32'(an), 32'(an_of(shown())));
            if ((cyc - 1) % 4 == 0) begin
                check("l1_seg", 32'(seg), 32'(exp1259[shown()]));
                check("l1_dp", 32'(dp), shown() == 2 ? 32'h0 : 32'h1);
            end
        end

        do_load(16'h00A3, 4'b0000);
        check_digit("a3_d0", 0, 7'h30);
        check_digit("a3_d1", 1, 7'h3F);
        check_digit("a3_d2", 2, LZ);

        for (int k = 0; k < 8 && cyc % 4 != 3; k++) tick();
        v = 16'h8642;
        digits_in = v;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("tc_an", 32'(an), 32'(an_of(shown())));
        check("tc_seg", 32'(seg), 32'(code[v[4*shown() +: 4]]));

        goto(2);
        check("mr_pre_an", 32'(an), 32'hB);
        #2 reset = 1'b1;
        #1;
        check("mr_an", 32'(an), 32'hF);
        check("mr_seg", 32'(seg), 32'h7F);
        check("mr_fd", 32'(frame_done), 32'h0);
        @(posedge clki);
        #1 reset = 1'b0;
        cyc = 0;
        tick();
        check("mr_rel_an", 32'(an), 32'hE);
        check("mr_rel_seg", 32'(seg), 32'h40);
        check_digit("mr_d3", 3, LZ);

        do_load(16'h0070, 4'b0000);
        check_digit("bl_d0", 0, 7'h40);
        check_digit("bl_d1", 1, 7'h78);
        check_digit("bl_d2", 2, LZ);
        check_digit("bl_d3", 3, LZ);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
